// File: rtl/uart_rx_controller.sv
// 8N1 UART receiver: 16x oversampled with a mid-bit start check and a stop-bit check.
// Also keeps byte and newline counters for the display path.
module uart_rx_controller #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned BYTE_CNT_W = 16
) (
  input  logic                  system_clock,
  input  logic                  rst,
  input  logic                  clock_enable,
  input  logic                  rx,
  input  logic                  counters_clear,
  output logic [7:0]            rx_data,
  output logic                  rx_valid,
  output logic                  frame_error,
  output logic                  busy,
  output logic [BYTE_CNT_W-1:0] byte_counter,
  output logic [7:0]            line_counter
);

  localparam int unsigned TICK_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned BIT_W  = 3;
  localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(7);
  localparam logic [7:0]        NEWLINE   = 8'h0A;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    STOP       = 3'd3,
    BREAK_WAIT = 3'd4
  } state_t;

  state_t            state, state_next;
  logic [1:0]        sync;
  logic              rx_s;
  logic [TICK_W-1:0] tick_cnt, tick_next;
  logic [BIT_W-1:0]  bit_cnt, bit_next;
  logic [7:0]        shreg, shreg_next;
  logic              valid_c, ferr_c;

  assign rx_s = sync[1];

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge system_clock or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], rx};
  end

  always_ff @(posedge system_clock or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and datapath updates; nothing advances between clock_enable ticks.
  always_comb begin
    state_next = state;
    tick_next  = tick_cnt;
    bit_next   = bit_cnt;
    shreg_next = shreg;
    valid_c    = 1'b0;
    ferr_c     = 1'b0;
    if (clock_enable) begin
      tick_next = tick_cnt + TICK_W'(1);
      case (state)
        IDLE: begin
          tick_next = '0;
          if (!rx_s) state_next = START;
        end
        START: begin
          if (tick_cnt == MID_TICK) begin
            tick_next  = '0;
            bit_next   = '0;
            state_next = rx_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (tick_cnt == LAST_TICK) begin
            tick_next  = '0;
            shreg_next = {rx_s, shreg[7:1]};
            bit_next   = bit_cnt + BIT_W'(1);
            if (bit_cnt == LAST_BIT) state_next = STOP;
          end
        end
        STOP: begin
          if (tick_cnt == LAST_TICK) begin
            tick_next = '0;
            if (rx_s) begin
              valid_c    = 1'b1;
              state_next = IDLE;
            end else begin
              ferr_c     = 1'b1;
              state_next = BREAK_WAIT;
            end
          end
        end
        BREAK_WAIT: begin
          // Hold here while the line stays low so a break cannot retrigger a frame.
          tick_next = '0;
          if (rx_s) state_next = IDLE;
        end
        default: begin
          tick_next  = '0;
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge system_clock or posedge rst) begin
    if (rst) begin
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
    end else begin
      tick_cnt    <= tick_next;
      bit_cnt     <= bit_next;
      shreg       <= shreg_next;
      rx_valid    <= valid_c;
      frame_error <= ferr_c;
      busy        <= (state_next != IDLE);
      if (valid_c) rx_data <= shreg;
    end
  end

  // Clear takes priority over a coincident increment.
  always_ff @(posedge system_clock or posedge rst) begin
    if (rst) begin
      byte_counter <= '0;
      line_counter <= '0;
    end else if (counters_clear) begin
      byte_counter <= '0;
      line_counter <= '0;
    end else if (valid_c) begin
      byte_counter <= byte_counter + BYTE_CNT_W'(1);
      if (shreg == NEWLINE) line_counter <= line_counter + 8'(1);
    end
  end

endmodule

// File: tb/tb_uart_rx_controller.sv
// Bench for uart_rx_controller: drives 8N1 frames and checks outputs every cycle against a queue-based
// expectation model, plus literal expectations at the end of each scenario.
module tb_uart_rx_controller;

  localparam int unsigned OS     = 16;
  localparam int unsigned BW     = 4;
  localparam int unsigned CE_DIV = 4;
  localparam int unsigned FRAME_BUSY_CYCLES = (OS / 2 + OS * 9) * CE_DIV;

  logic          system_clock = 1'b0;
  logic          rst = 1'b0;
  logic          clock_enable = 1'b0;
  logic          rx = 1'b1;
  logic          counters_clear = 1'b0;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          frame_error;
  logic          busy;
  logic [BW-1:0] byte_counter;
  logic [7:0]    line_counter;

  int n_checks = 0;
  int n_pass = 0;
  int n_valid = 0;
  int n_ferr = 0;
  int busy_cycles = 0;
  logic busy_seen = 1'b0;
  logic clr_seen = 1'b0;

  // Expected strobes in order: bit 8 set = framing error, else good byte in bits 7:0.
  logic [8:0]    exp_q[$];
  logic [8:0]    e_front;
  logic [7:0]    m_data = 8'h00;
  logic [BW-1:0] m_bytes = '0;
  logic [7:0]    m_lines = 8'h00;

  uart_rx_controller #(.OVERSAMPLE(OS), .BYTE_CNT_W(BW)) dut (
    .system_clock  (system_clock),
    .rst           (rst),
    .clock_enable  (clock_enable),
    .rx            (rx),
    .counters_clear(counters_clear),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .frame_error   (frame_error),
    .busy          (busy),
    .byte_counter  (byte_counter),
    .line_counter  (line_counter)
  );

  always #5 system_clock = ~system_clock;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endfunction

  // One clock_enable pulse every CE_DIV cycles.
  initial begin
    int div;
    div = 0;
    forever begin
      @(posedge system_clock);
      #1;
      div = (div + 1) % CE_DIV;
      clock_enable = (div == 0);
    end
  end

  always @(posedge system_clock) clr_seen <= counters_clear;

  always @(negedge system_clock) begin
    if (busy) begin
      busy_seen = 1'b1;
      busy_cycles++;
    end
    if (rst) begin
      m_data  = 8'h00;
      m_bytes = '0;
      m_lines = 8'h00;
      exp_q.delete();
      chk("rst_rx_valid", 32'(rx_valid), 32'd0);
      chk("rst_frame_error", 32'(frame_error), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end else begin
      if (rx_valid || frame_error) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", 32'({rx_valid, frame_error}), 32'd0);
        end else begin
          e_front = exp_q.pop_front();
          chk("strobe_kind", 32'({rx_valid, frame_error}), e_front[8] ? 32'd1 : 32'd2);
          if (!e_front[8]) begin
            n_valid++;
            m_data = e_front[7:0];
            if (!clr_seen) begin
              m_bytes = m_bytes + BW'(1);
              if (e_front[7:0] == 8'h0A) m_lines = m_lines + 8'(1);
            end
          end else begin
            n_ferr++;
          end
        end
      end
      if (clr_seen) begin
        m_bytes = '0;
        m_lines = 8'h00;
      end
    end
    chk("rx_data", 32'(rx_data), 32'(m_data));
    chk("byte_counter", 32'(byte_counter), 32'(m_bytes));
    chk("line_counter", 32'(line_counter), 32'(m_lines));
  end

  task automatic wait_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge system_clock);
      if (clock_enable) k++;
    end
    #2;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    exp_q.push_back({~stop_bit, d});
    rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_ticks(OS);
    end
    rx = stop_bit;
    wait_ticks(OS);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge system_clock);
    #2;
    chk("reset_rx_data", 32'(rx_data), 32'h0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_byte_counter", 32'(byte_counter), 32'd0);
    rst = 1'b0;
    wait_ticks(4);

    // Good byte, with exact busy duration
    busy_cycles = 0;
    send_frame(8'h55, 1'b1);
    wait_ticks(2);
    chk("busy_cycles_55", 32'(busy_cycles), 32'(FRAME_BUSY_CYCLES));
    chk("n_valid_55", 32'(n_valid), 32'd1);
    chk("rx_data_55", 32'(rx_data), 32'h55);
    chk("bytes_55", 32'(byte_counter), 32'd1);
    chk("lines_55", 32'(line_counter), 32'd0);
    chk("drained_55", 32'(exp_q.size()), 32'd0);

    // Glitch start
    busy_seen = 1'b0;
    rx = 1'b0;
    wait_ticks(3);
    rx = 1'b1;
    wait_ticks(12);
    chk("glitch_busy_seen", 32'(busy_seen), 32'd1);
    chk("glitch_busy_after", 32'(busy), 32'd0);
    chk("glitch_no_strobe", 32'(n_valid + n_ferr), 32'd1);
    send_frame(8'hA3, 1'b1);
    wait_ticks(2);
    chk("rx_data_a3", 32'(rx_data), 32'hA3);
    chk("bytes_a3", 32'(byte_counter), 32'd2);

    // Framing error followed by a held-low line
    send_frame(8'h3C, 1'b0);
    wait_ticks(40);
    chk("ferr_count", 32'(n_ferr), 32'd1);
    chk("ferr_busy_held", 32'(busy), 32'd1);
    chk("ferr_rx_data", 32'(rx_data), 32'hA3);
    chk("ferr_bytes", 32'(byte_counter), 32'd2);
    rx = 1'b1;
    wait_ticks(3);
    chk("ferr_released", 32'(busy), 32'd0);
    send_frame(8'h0F, 1'b1);
    wait_ticks(2);
    chk("rx_data_0f", 32'(rx_data), 32'h0F);
    chk("bytes_0f", 32'(byte_counter), 32'd3);

    // Newlines, back to back
    send_frame(8'h0A, 1'b1);
    send_frame(8'h41, 1'b1);
    send_frame(8'h0A, 1'b1);
    wait_ticks(2);
    chk("b2b_n_valid", 32'(n_valid), 32'd6);
    chk("b2b_bytes", 32'(byte_counter), 32'd6);
    chk("b2b_lines", 32'(line_counter), 32'd2);
    chk("b2b_rx_data", 32'(rx_data), 32'h0A);

    // Counter wrap (4-bit byte counter in this bench)
    for (int i = 0; i < 9; i++) send_frame(8'(8'h10 + i), 1'b1);
    wait_ticks(2);
    chk("wrap_pre", 32'(byte_counter), 32'd15);
    send_frame(8'h7E, 1'b1);
    wait_ticks(2);
    chk("wrap_zero", 32'(byte_counter), 32'd0);
    chk("wrap_lines", 32'(line_counter), 32'd2);

    // Clear held across a received newline
    counters_clear = 1'b1;
    send_frame(8'h0A, 1'b1);
    wait_ticks(2);
    counters_clear = 1'b0;
    wait_ticks(1);
    chk("clear_bytes", 32'(byte_counter), 32'd0);
    chk("clear_lines", 32'(line_counter), 32'd0);
    chk("clear_rx_data", 32'(rx_data), 32'h0A);

    // Reset after the 4th data bit of 0xFF
    rx = 1'b0;
    wait_ticks(OS);
    rx = 1'b1;
    wait_ticks(4 * OS);
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rx_data", 32'(rx_data), 32'h0);
    chk("midrst_valid", 32'(rx_valid), 32'd0);
    chk("midrst_ferr", 32'(frame_error), 32'd0);
    repeat (3) @(posedge system_clock);
    #2 rst = 1'b0;
    wait_ticks(4);
    send_frame(8'h81, 1'b1);
    wait_ticks(2);
    chk("post_rst_rx_data", 32'(rx_data), 32'h81);
    chk("post_rst_bytes", 32'(byte_counter), 32'd1);
    chk("post_rst_lines", 32'(line_counter), 32'd0);
    chk("drained_end", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_controller.md
# uart_rx_controller

- Receive-side counterpart of the UART transmit controller.
- Recovers 8N1 frames from the serial `rx` line:
  - samples with a 16x-baud clock enable from the board clock divider;
  - rejects glitch starts;
  - checks the stop bit.
- Presents each good byte with a one-cycle valid strobe, plus running byte and newline counters for the seven-segment display path.

## Interface

Parameters:
- `OVERSAMPLE`, 16: clock_enable ticks per bit; mid-bit offset is `OVERSAMPLE/2`.
- `BYTE_CNT_W`, 16: width of `byte_counter`.

Ports:
- `system_clock`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clock_enable`  in  1  one-cycle pulse at 16x baud, from the clock divider.
- `rx`  in  1  asynchronous serial input; idles high.
- `counters_clear`  in  1  synchronous clear of both counters.
- `rx_data`  out  8  last good byte; holds until the next good byte.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates.
- `frame_error`  out  1  one-cycle pulse when the stop bit is sampled low.
- `busy`  out  1  high in any state except IDLE.
- `byte_counter`  out  BYTE_CNT_W  good bytes received; wraps.
- `line_counter`  out  8  good bytes equal to 0x0A; wraps.

## Operation

- **Input synchronizer**
  - `rx` passes through a 2-flop synchronizer (reset value 1) to produce `rx_s`.
  - All decisions use `rx_s`.
- **Tick counter**
  - `tick_cnt` is 4 bits and advances only on `clock_enable`.
  - It is cleared on every state entry.
- **State machine** (states IDLE, START, DATA, STOP, BREAK_WAIT):
  - **IDLE:** on a `clock_enable` with `rx_s`=0, go to START with `tick_cnt`=0.
  - **START:** on the tick where `tick_cnt`=OVERSAMPLE/2-1, sample `rx_s`.
    - If 1 (false start), go to IDLE with no strobe.
    - If 0, go to DATA with `bit_cnt`=0.
  - **DATA:** on the tick where `tick_cnt`=OVERSAMPLE-1:
    - shift right, `shreg <= {rx_s, shreg[7:1]}` (LSB first);
    - `bit_cnt`++;
    - after the 8th bit, go to STOP.
  - **STOP:** on the tick where `tick_cnt`=OVERSAMPLE-1, sample `rx_s`.
    - If 1: load `rx_data <= shreg`, pulse `rx_valid`, `byte_counter`++, `line_counter`++ if `shreg`==8'h0A, go to IDLE.
    - If 0: pulse `frame_error`, leave `rx_data` and the counters unchanged, go to BREAK_WAIT.
  - **BREAK_WAIT:** stay until a `clock_enable` tick with `rx_s`=1, then go to IDLE. This stops a held-low line from retriggering.
- **Counters**
  - Both counters wrap to 0 modulo their width.
  - `counters_clear` zeroes both counters on the next edge.
  - Clear wins over a simultaneous increment.
  - Clear does not affect the FSM, `rx_data`, or the strobes.
- `clock_enable` is ignored outside a pulse cycle. The FSM does not advance between ticks.

## Timing

- Reset values:
  - state IDLE;
  - `rx_data`=0, `rx_valid`=0, `frame_error`=0, `busy`=0;
  - `byte_counter`=0, `line_counter`=0;
  - synchronizer=1, `shreg`=0.
- Input latency: a falling edge on `rx` reaches `rx_s` 2 `system_clock` cycles later. It is seen on the first `clock_enable` after that.
- Start and data sampling:
  - the start bit is sampled 8 ticks after detection (mid-bit);
  - each data bit and the stop bit are sampled every 16 ticks after that.
- Strobes:
  - `rx_valid` and `frame_error` go high in the cycle after the stop-sample edge, for exactly 1 `system_clock` cycle;
  - `rx_data` and the counters update on the same edge.
- `busy`:
  - rises on the edge entering START;
  - falls on the edge returning to IDLE, coincident with `rx_valid` rising;
  - stays high through BREAK_WAIT.
- Back-to-back frames: a new start bit is accepted on the first tick after returning to IDLE. The design tolerates a stop bit shortened by up to 8 ticks.
- Asynchronous `rst` mid-frame aborts immediately:
  - no strobe is issued;
  - partial `shreg` contents are discarded;
  - the first frame after release is received normally.

## Test plan

- **Good byte:** reset, then 16x `clock_enable`; drive 0x55 as an 8N1 frame. Expect:
  - exactly one `rx_valid` pulse;
  - `rx_data`=0x55, `byte_counter`=1, `line_counter`=0;
  - `busy` high for about 9.5 bit times.
- **Glitch start:** pull `rx` low for 3 ticks, then high. Expect:
  - `busy` pulses, no `rx_valid` and no `frame_error`;
  - FSM back in IDLE; the next 0xA3 frame is received correctly.
- **Framing error:** send 0x3C with the stop bit low, then hold low 40 ticks, then release. Expect:
  - one `frame_error` pulse;
  - `rx_data` and `byte_counter` unchanged;
  - no retrigger until `rx` returns high;
  - a following 0x0F is received correctly.
- **Newline and back-to-back:** send 0x0A, 0x41, 0x0A with no idle gap. Expect:
  - three `rx_valid` pulses with data 0x0A, 0x41, 0x0A in order;
  - `byte_counter`=3, `line_counter`=2.
- **Wrap and clear:** preload via 65535 good bytes (or force the counter), then send one more byte. Expect:
  - `byte_counter`=0;
  - asserting `counters_clear` in the same cycle as an `rx_valid` leaves both counters at 0.
- **Reset mid-frame:** assert `rst` after the 4th data bit of 0xFF. Expect:
  - all outputs at reset values immediately, no strobe;
  - after release, 0x81 received with `byte_counter`=1.
